cache_generator_issue: RTL
==========================

# cache_generator_issue

Cache-side issue stage sitting directly downstream of the cache request generator.
- Pops one `CacheRequest` at a time from the generator's request FIFO and drives the cache frontend iob handshake.
- Holds the request stable until the cache accepts it, then captures read data.
- Pushes a `MemoryPacket` response into a 16-deep response FIFO for the memory requestors.

## Interface
Parameters:
- `POP_WAIT_CYCLES`, 4: cycles waited for `request_in.valid` after a pop before treating the generator FIFO as empty. Matches the pop round trip: generator rd_en reg, FIFO valid, generator output reg, local input reg.
- `RESPONSE_FIFO_DEPTH`, 16: response FIFO depth.
- `RESPONSE_PROG_THRESH`, 8: response FIFO prog_full threshold.

Ports:
- `ap_clk` in 1: clock. One clock; all logic on its rising edge.
- `areset` in 1: reset. Synchronous, active-high.
- `request_in` in `CacheRequest`: request from the generator's `request_out`.
- `fifo_request_signals_out` out `FIFOStateSignalsInput`: only `.rd_en` is driven (pop strobe to the generator); all other fields are 0.
- `cache_iob_valid` out 1: request valid to cache.
- `cache_iob_addr` out `CACHE_FRONTEND_ADDR_W`: request address.
- `cache_iob_wdata` out `CACHE_FRONTEND_DATA_W`: write data.
- `cache_iob_wstrb` out `CACHE_FRONTEND_NBYTES`: byte strobes. Value 0 means read.
- `cache_iob_rdata` in `CACHE_FRONTEND_DATA_W`: read data, valid while `cache_iob_ready` is 1.
- `cache_iob_ready` in 1: cache accept/complete strobe.
- `fifo_response_signals_in` in `FIFOStateSignalsInput`: consumer `.rd_en`.
- `fifo_response_signals_out` out `FIFOStateSignalsOutput`: response FIFO state, registered.
- `response_out` out `MemoryPacket`: popped response.
- `fifo_setup_signal` out 1: response FIFO is in reset (`wr_rst_busy | rd_rst_busy`), registered.

## Operation
- **Reset handling.** `areset` is registered once into separate control and FIFO resets. All input ports except the cache iob inputs are registered once before use.
- **FSM states:** IDLE, POP, WAIT, ISSUE, RESP.
  - IDLE: if response FIFO not prog_full and `fifo_setup_signal` is 0, go to POP. Otherwise stay.
  - POP: assert `.rd_en` for exactly one cycle, clear the wait counter, go to WAIT.
  - WAIT: if registered `request_in.valid` is 1, latch the payload (iob + meta) and go to ISSUE. Otherwise increment the wait counter; when it reaches `POP_WAIT_CYCLES`, return to IDLE (the generator FIFO was empty).
  - ISSUE: hold `cache_iob_valid` at 1 with addr/wdata/wstrb stable from the latch.
    - When `cache_iob_ready` is 1, drop `cache_iob_valid` in the next cycle.
    - Read (wstrb == 0): capture `cache_iob_rdata` and go to RESP.
    - Write: behaviour depends on the configuration macro.
  - RESP: write one entry to the response FIFO, then go to IDLE.
- **Response packet contents:**
  - `payload.meta` = latched meta, with `subclass.cmd` overwritten to `CMD_MEM_RESPONSE`.
  - `payload.data.field_0` = captured rdata. Other data fields are 0.
  - `valid` = 1.
- **Single outstanding request.** At most one request is outstanding; a new pop never occurs before ISSUE completes.
- **Pop is blocked, not dropped.** A request already popped is never dropped: if the response FIFO fills while the block is in ISSUE, the RESP push still occurs. The prog_full threshold guarantees room.
- **Response FIFO read side.** Pop only when `.rd_en` is set and the FIFO is not empty. `response_out.valid` = FIFO `valid`, registered.
- **Write to full FIFO.** A response FIFO write attempted while full is a design error; the bench checks it never happens.

## Timing
- **Reset values** (reached by the second cycle after `areset` is sampled high):
  - `cache_iob_valid` 0, `.rd_en` 0, `response_out.valid` 0.
  - `fifo_setup_signal` 1.
  - FSM in IDLE, wait counter 0.
  - The response FIFO is cleared; any in-flight cache transaction is abandoned.
  - `fifo_response_signals_out` reflects the FIFO reset state (registered).
- **Pop to issue:** `.rd_en` pulse in cycle T. With the generator non-empty, registered `request_in.valid` is seen no later than T+4, and `cache_iob_valid` rises on the following cycle.
- **Ready same cycle as valid:** if `cache_iob_ready` is 1 in the first ISSUE cycle, the request completes in 1 cycle.
- **Complete to response:** rdata captured on ready in cycle R; RESP writes the FIFO in cycle R+1; FIFO `valid` and registered `response_out.valid` follow the FIFO read latency plus one register.
- **Back-to-back throughput:** best case one request per 8 cycles.
- **Late valid after timeout:** if `request_in.valid` arrives after the WAIT timeout, it is not latched; the generator holds it in its output register only one cycle, so this must not occur with `POP_WAIT_CYCLES` ≥ 4.

## Configuration
- **`CACHE_GENERATOR_WRITE_ACK_EN` defined:** a completed write also goes to RESP. The response has `cmd` = `CMD_MEM_RESPONSE` and `data.field_0` = 0, so requestors can count write completions.
- **Undefined:** a completed write returns directly to IDLE and no response is produced.

## Test plan
- **Read:** generator supplies read addr 0x40. Cache asserts ready 3 cycles after valid with rdata 0xDEADBEEF. Expect one response with `field_0` = 0xDEADBEEF, `cmd` = `CMD_MEM_RESPONSE`, and address/meta preserved.
- **Write, both builds:** write with wdata 0x1234, wstrb all-ones. Expect cache sees stable wdata/wstrb until ready. Expect 1 response with macro defined, 0 without.
- **Empty generator:** no requests. Expect one `.rd_en` pulse every `POP_WAIT_CYCLES`+2 cycles, `cache_iob_valid` never high, no responses.
- **Backpressure:** consumer `.rd_en` held 0 while 20 reads run. Expect pops stop once prog_full (8) is reached, no FIFO overflow, then all 20 responses arrive in order after the consumer drains.
- **Reset mid-ISSUE:** `areset` pulsed while `cache_iob_valid` is 1. Expect `cache_iob_valid` 0 within 2 cycles, `fifo_setup_signal` 1, FIFO empty, and normal operation on the next request after reset.

Source files
------------

// File: rtl/cache_generator_issue.sv
// Cache issue stage: pops generator requests, drives the cache iob handshake and queues MemoryPacket responses.
// Build option CACHE_GENERATOR_WRITE_ACK_EN: completed writes also push a zero-data response.

package cache_generator_issue_pkg;
    localparam int CACHE_FRONTEND_ADDR_W = 32;
    localparam int CACHE_FRONTEND_DATA_W = 32;
    localparam int CACHE_FRONTEND_NBYTES = 4;

    localparam logic [1:0] CMD_MEM_READ     = 2'd0;
    localparam logic [1:0] CMD_MEM_WRITE    = 2'd1;
    localparam logic [1:0] CMD_MEM_RESPONSE = 2'd2;

    typedef struct packed {
        logic [1:0] cmd;
    } SubclassPacket;

    typedef struct packed {
        logic [7:0]                       id;
        SubclassPacket                    subclass;
        logic [CACHE_FRONTEND_ADDR_W-1:0] address;
    } MetaPacket;

    typedef struct packed {
        logic [CACHE_FRONTEND_ADDR_W-1:0] addr;
        logic [CACHE_FRONTEND_DATA_W-1:0] wdata;
        logic [CACHE_FRONTEND_NBYTES-1:0] wstrb;
    } IobPacket;

    typedef struct packed {
        logic      valid;
        IobPacket  iob;
        MetaPacket meta;
    } CacheRequest;

    typedef struct packed {
        logic [CACHE_FRONTEND_DATA_W-1:0] field_0;
        logic [CACHE_FRONTEND_DATA_W-1:0] field_1;
    } DataPacket;

    typedef struct packed {
        MetaPacket meta;
        DataPacket data;
    } MemoryPayload;

    typedef struct packed {
        logic         valid;
        MemoryPayload payload;
    } MemoryPacket;

    typedef struct packed {
        logic rd_en;
        logic wr_en;
    } FIFOStateSignalsInput;

    typedef struct packed {
        logic full;
        logic empty;
        logic prog_full;
        logic valid;
        logic wr_rst_busy;
        logic rd_rst_busy;
    } FIFOStateSignalsOutput;

    localparam int CACHE_REQUEST_W = $bits(CacheRequest);
    localparam int MEMORY_PACKET_W = $bits(MemoryPacket);
    localparam int FIFO_IN_W       = $bits(FIFOStateSignalsInput);
    localparam int FIFO_OUT_W      = $bits(FIFOStateSignalsOutput);
endpackage

module cache_generator_issue
    import cache_generator_issue_pkg::*;
#(
    parameter int POP_WAIT_CYCLES      = 4,
    parameter int RESPONSE_FIFO_DEPTH  = 16,
    parameter int RESPONSE_PROG_THRESH = 8
) (
    input  logic                             ap_clk,
    input  logic                             areset,
    input  logic [CACHE_REQUEST_W-1:0]       request_in,
    output logic [FIFO_IN_W-1:0]             fifo_request_signals_out,
    output logic                             cache_iob_valid,
    output logic [CACHE_FRONTEND_ADDR_W-1:0] cache_iob_addr,
    output logic [CACHE_FRONTEND_DATA_W-1:0] cache_iob_wdata,
    output logic [CACHE_FRONTEND_NBYTES-1:0] cache_iob_wstrb,
    input  logic [CACHE_FRONTEND_DATA_W-1:0] cache_iob_rdata,
    input  logic                             cache_iob_ready,
    input  logic [FIFO_IN_W-1:0]             fifo_response_signals_in,
    output logic [FIFO_OUT_W-1:0]            fifo_response_signals_out,
    output logic [MEMORY_PACKET_W-1:0]       response_out,
    output logic                             fifo_setup_signal
);

    typedef enum logic [2:0] {IDLE, POP, WAIT, ISSUE, RESP} state_t;

    localparam int CNT_W = $clog2(POP_WAIT_CYCLES + 1);
    localparam int PTR_W = $clog2(RESPONSE_FIFO_DEPTH);
    localparam int LVL_W = $clog2(RESPONSE_FIFO_DEPTH + 1);

    function automatic MemoryPayload build_response(input MetaPacket meta,
                                                    input logic [CACHE_FRONTEND_DATA_W-1:0] rdata);
        MemoryPayload p;
        p                   = '0;
        p.meta              = meta;
        p.meta.subclass.cmd = CMD_MEM_RESPONSE;
        p.data.field_0      = rdata;
        return p;
    endfunction

    // Stage p0: registered reset copies and registered inputs
    CacheRequest          req_in;
    FIFOStateSignalsInput rsp_in;
    logic                 ctrl_rst, fifo_rst;
    logic                 req_vld_p0, rsp_rd_en_p0;
    IobPacket             req_iob_p0;
    MetaPacket            req_meta_p0;
    logic                 unused_ok;

    assign req_in    = request_in;
    assign rsp_in    = fifo_response_signals_in;
    assign unused_ok = rsp_in.wr_en;

    always_ff @(posedge ap_clk) begin
        ctrl_rst    <= areset;
        fifo_rst    <= areset;
        req_iob_p0  <= req_in.iob;
        req_meta_p0 <= req_in.meta;
        if (ctrl_rst) begin
            req_vld_p0   <= 1'b0;
            rsp_rd_en_p0 <= 1'b0;
        end else begin
            req_vld_p0   <= req_in.valid;
            rsp_rd_en_p0 <= rsp_in.rd_en;
        end
    end

    // Stage p1: issue FSM and latched request
    state_t                           state;
    logic [CNT_W-1:0]                 wait_cnt;
    logic                             pop_q, iob_vld_q;
    IobPacket                         iob_q;
    MetaPacket                        meta_q;
    logic [CACHE_FRONTEND_DATA_W-1:0] rdata_q;
    logic                             fifo_full, fifo_empty, fifo_prog_full;

    always_ff @(posedge ap_clk) begin
        if (ctrl_rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            pop_q     <= 1'b0;
            iob_vld_q <= 1'b0;
        end else begin
            pop_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_prog_full && !fifo_setup_signal) begin
                        state <= POP;
                        pop_q <= 1'b1;
                    end
                end
                POP: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                    if (req_vld_p0) begin
                        iob_vld_q <= 1'b1;
                        state     <= ISSUE;
                    end else if (wait_cnt == CNT_W'(POP_WAIT_CYCLES - 1)) begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    if (cache_iob_ready) begin
                        iob_vld_q <= 1'b0;
`ifdef CACHE_GENERATOR_WRITE_ACK_EN
                        state <= RESP;
`else
                        state <= (iob_q.wstrb == '0) ? RESP : IDLE;
`endif
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Write completions carry zero data so requestors only count them
    always_ff @(posedge ap_clk) begin
        if (state == WAIT && req_vld_p0) begin
            iob_q  <= req_iob_p0;
            meta_q <= req_meta_p0;
        end
        if (state == ISSUE && cache_iob_ready)
            rdata_q <= (iob_q.wstrb == '0) ? cache_iob_rdata : '0;
    end

    assign cache_iob_valid = iob_vld_q;
    assign cache_iob_addr  = iob_q.addr;
    assign cache_iob_wdata = iob_q.wdata;
    assign cache_iob_wstrb = iob_q.wstrb;

    always_comb begin
        FIFOStateSignalsInput req_sig;
        req_sig                  = '0;
        req_sig.rd_en            = pop_q;
        fifo_request_signals_out = req_sig;
    end

    // Stage p2: response FIFO
    MemoryPayload     mem [RESPONSE_FIFO_DEPTH];
    MemoryPayload     fifo_dout;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             wr_fire, rd_fire, fifo_valid, rd_busy;

    assign fifo_full      = (level == LVL_W'(RESPONSE_FIFO_DEPTH));
    assign fifo_empty     = (level == '0);
    assign fifo_prog_full = (level >= LVL_W'(RESPONSE_PROG_THRESH));
    assign wr_fire        = (state == RESP) && !fifo_full && !fifo_rst;
    assign rd_fire        = rsp_rd_en_p0 && !fifo_empty && !fifo_rst;

    always_ff @(posedge ap_clk) begin
        if (wr_fire)
            mem[wr_ptr] <= build_response(meta_q, rdata_q);
        if (rd_fire)
            fifo_dout <= mem[rd_ptr];
    end

    always_ff @(posedge ap_clk) begin
        rd_busy <= fifo_rst;
        if (fifo_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            fifo_valid <= 1'b0;
        end else begin
            fifo_valid <= rd_fire;
            if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_fire, rd_fire})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Stage p3: registered FIFO state and response outputs
    FIFOStateSignalsOutput status_q;
    MemoryPacket           rsp_q;

    always_ff @(posedge ap_clk) begin
        fifo_setup_signal    <= fifo_rst | rd_busy;
        status_q.full        <= fifo_full;
        status_q.empty       <= fifo_empty;
        status_q.prog_full   <= fifo_prog_full;
        status_q.valid       <= fifo_valid;
        status_q.wr_rst_busy <= fifo_rst;
        status_q.rd_rst_busy <= rd_busy;
        rsp_q.payload        <= fifo_dout;
        if (fifo_rst)
            rsp_q.valid <= 1'b0;
        else
            rsp_q.valid <= fifo_valid;
    end

    assign fifo_response_signals_out = status_q;
    assign response_out              = rsp_q;

endmodule
